// File: rtl/std_mem_init_pkg.sv
// Shared types for the std_mem_d1 burst initiator: FSM state encoding and
// burst direction codes.
package std_mem_init_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_FETCH,
      RD_SEND,
      WR_DATA,
      WR_MEM,
      WR_WAIT,
      DONE
   } state_e;

   localparam logic DIR_RD = 1'b0;
   localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/std_mem_d1_initiator.sv
// Burst initiator for one std_mem_d1 port: streams memory words out on a
// valid/ready port (read) or commits streamed words to memory (write).
module std_mem_d1_initiator
   import std_mem_init_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int SIZE      = 16,
   parameter int IDX_SIZE  = 4,
   parameter int LEN_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 go,
   input  logic                 dir,
   input  logic [IDX_SIZE-1:0]  base,
   input  logic [LEN_WIDTH-1:0] len,
   output logic                 done,
   output logic                 busy,
   output logic [IDX_SIZE-1:0]  mem_addr0,
   output logic [WIDTH-1:0]     mem_write_data,
   output logic                 mem_write_en,
   input  logic [WIDTH-1:0]     mem_read_data,
   input  logic                 mem_done,
   output logic [WIDTH-1:0]     rd_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 wr_valid,
   output logic                 wr_ready
);

   state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0] count_q;
   logic [LEN_WIDTH-1:0] len_q;
   logic [IDX_SIZE-1:0]  addr_q;
   logic [IDX_SIZE-1:0]  addr_hold_q;
   logic [WIDTH-1:0]     rd_data_q;
   logic [WIDTH-1:0]     wdata_q;

   logic more_words;
   logic rd_advance;
   logic rd_capture;
   logic wr_advance;
   logic addr_drive;

   // The address wraps at the memory depth, not at the address-width limit.
   function automatic logic [IDX_SIZE-1:0] wrap_inc(input logic [IDX_SIZE-1:0] a);
      return (a == IDX_SIZE'(SIZE - 1)) ? '0 : a + 1'b1;
   endfunction

   assign more_words = (count_q != len_q);
   assign rd_advance = (state_q == RD_SEND) && rd_ready && more_words;
   assign rd_capture = (state_q == RD_FETCH) || rd_advance;
   assign wr_advance = (state_q == WR_WAIT) && mem_done;
   assign addr_drive = rd_capture || (state_q == WR_MEM);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (go) begin
               if (len == '0)
                  state_d = DONE;
               else if (dir == DIR_WR)
                  state_d = WR_DATA;
               else
                  state_d = RD_FETCH;
            end
         end
         RD_FETCH: state_d = RD_SEND;
         RD_SEND: begin
            if (rd_ready && !more_words)
               state_d = DONE;
         end
         WR_DATA: begin
            if (wr_valid)
               state_d = WR_MEM;
         end
         WR_MEM:  state_d = WR_WAIT;
         WR_WAIT: begin
            if (mem_done)
               state_d = ((count_q + 1'b1) == len_q) ? DONE : WR_DATA;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy           = (state_q != IDLE);
      done           = (state_q == DONE);
      rd_valid       = (state_q == RD_SEND);
      wr_ready       = (state_q == WR_DATA);
      mem_write_en   = (state_q == WR_MEM);
      mem_addr0      = addr_drive ? addr_q : addr_hold_q;
      rd_data        = rd_data_q;
      mem_write_data = wdata_q;
   end

   // addr_q always tracks base + count (wrapped), so no adder is needed per access.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q     <= '0;
         len_q       <= '0;
         addr_q      <= '0;
         addr_hold_q <= '0;
         rd_data_q   <= '0;
         wdata_q     <= '0;
      end else begin
         if (state_q == IDLE && go) begin
            count_q <= '0;
            len_q   <= len;
            addr_q  <= base;
         end
         if (rd_capture) begin
            rd_data_q <= mem_read_data;
         end
         if (rd_capture || wr_advance) begin
            count_q <= count_q + 1'b1;
            addr_q  <= wrap_inc(addr_q);
         end
         if (state_q == WR_DATA && wr_valid) begin
            wdata_q <= wr_data;
         end
         if (addr_drive) begin
            addr_hold_q <= addr_q;
         end
      end
   end

endmodule

// File: tb/tb_std_mem_d1_initiator.sv
// Directed bench for std_mem_d1_initiator with a combinational-read memory
// model that acknowledges writes one cycle after the strobe.
module tb_std_mem_d1_initiator;

   logic        clk = 1'b0;
   logic        reset;
   logic        go;
   logic        dir;
   logic [3:0]  base;
   logic [4:0]  len;
   logic        done;
   logic        busy;
   logic [3:0]  mem_addr0;
   logic [31:0] mem_write_data;
   logic        mem_write_en;
   logic [31:0] mem_read_data;
   logic        mem_done;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic        wr_ready;

   logic [31:0] mem [16];
   logic        init_mem;
   int          hs_cnt   = 0;
   int          done_cnt = 0;
   int          act_cnt  = 0;
   int          errors   = 0;
   int          checks   = 0;

   std_mem_d1_initiator #(
      .WIDTH(32), .SIZE(16), .IDX_SIZE(4), .LEN_WIDTH(5)
   ) dut (
      .clk(clk), .reset(reset), .go(go), .dir(dir), .base(base), .len(len),
      .done(done), .busy(busy), .mem_addr0(mem_addr0),
      .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
      .mem_read_data(mem_read_data), .mem_done(mem_done),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready)
   );

   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_addr0];

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'(i * 10);
      end else if (mem_write_en) begin
         mem[mem_addr0] <= mem_write_data;
      end
      mem_done <= mem_write_en;
      if (rd_valid && rd_ready) hs_cnt <= hs_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (mem_write_en || rd_valid || wr_ready) act_cnt <= act_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
      $display("check %s: got %0h expected %0h", tag, got, exp);
   endtask

   initial begin
      int          exp1 [4];
      int          exp2 [4];
      logic [31:0] wexp [3];
      int          base_cnt;

      exp1 = '{20, 30, 40, 50};
      exp2 = '{140, 150, 0, 10};
      wexp = '{32'hA5A5_0001, 32'h5A5A_0002, 32'hDEAD_BEEF};

      reset = 1'b0; go = 1'b0; dir = 1'b0; base = '0; len = '0;
      rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0; init_mem = 1'b1;
      tick(); tick();
      init_mem = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_wr_ready", 32'(wr_ready), 32'd0);
      check("rst_wen", 32'(mem_write_en), 32'd0);
      check("rst_addr", 32'(mem_addr0), 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      reset = 1'b1;
      tick();

      // Read burst at full ready
      dir = 1'b0; base = 4'd2; len = 5'd4; rd_ready = 1'b1; go = 1'b1;
      tick(); go = 1'b0;
      check("rd1_busy", 32'(busy), 32'd1);
      check("rd1_fetch_addr", 32'(mem_addr0), 32'd2);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("rd1_valid", 32'(rd_valid), 32'd1);
         check("rd1_data", rd_data, 32'(exp1[k]));
      end
      tick();
      check("rd1_done", 32'(done), 32'd1);
      check("rd1_done_novalid", 32'(rd_valid), 32'd0);
      tick();
      check("rd1_idle_done", 32'(done), 32'd0);
      check("rd1_idle_busy", 32'(busy), 32'd0);

      // Read burst wrapping past SIZE-1 with stalled ready
      base_cnt = hs_cnt;
      dir = 1'b0; base = 4'd14; len = 5'd4; rd_ready = 1'b0; go = 1'b1;
      tick(); go = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         check("rd2_word", rd_data, 32'(exp2[k]));
         check("rd2_valid", 32'(rd_valid), 32'd1);
         tick();
         check("rd2_hold", rd_data, 32'(exp2[k]));
         rd_ready = 1'b1;
         tick();
         rd_ready = 1'b0;
      end
      check("rd2_done", 32'(done), 32'd1);
      tick();
      check("rd2_handshakes", 32'(hs_cnt - base_cnt), 32'd4);

      // Write burst
      base_cnt = done_cnt;
      dir = 1'b1; base = 4'd0; len = 5'd3; wr_data = wexp[0]; wr_valid = 1'b1; go = 1'b1;
      tick(); go = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("wr_ready_data", 32'(wr_ready), 32'd1);
         tick();
         check("wr_wen", 32'(mem_write_en), 32'd1);
         check("wr_ready_mem", 32'(wr_ready), 32'd0);
         check("wr_addr", 32'(mem_addr0), 32'(i));
         check("wr_wdata", mem_write_data, wexp[i]);
         if (i < 2) wr_data = wexp[i + 1];
         tick();
         check("wr_wen_wait", 32'(mem_write_en), 32'd0);
         check("wr_ready_wait", 32'(wr_ready), 32'd0);
         tick();
      end
      check("wr_done", 32'(done), 32'd1);
      wr_valid = 1'b0;
      tick();
      check("wr_done_low", 32'(done), 32'd0);
      check("wr_mem0", mem[0], wexp[0]);
      check("wr_mem1", mem[1], wexp[1]);
      check("wr_mem2", mem[2], wexp[2]);
      check("wr_done_pulses", 32'(done_cnt - base_cnt), 32'd1);

      // Zero-length command
      base_cnt = act_cnt;
      dir = 1'b1; base = 4'd0; len = 5'd0; go = 1'b1;
      tick(); go = 1'b0;
      check("len0_done", 32'(done), 32'd1);
      check("len0_busy", 32'(busy), 32'd1);
      tick();
      check("len0_done_low", 32'(done), 32'd0);
      check("len0_activity", 32'(act_cnt - base_cnt), 32'd0);

      // Reset in the middle of a read burst
      dir = 1'b0; base = 4'd0; len = 5'd8; rd_ready = 1'b1; go = 1'b1;
      tick(); go = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_rd_valid", 32'(rd_valid), 32'd0);
      check("mrst_rd_data", rd_data, 32'd0);
      check("mrst_addr", 32'(mem_addr0), 32'd0);
      check("mrst_wdata", mem_write_data, 32'd0);
      reset = 1'b1;
      dir = 1'b0; base = 4'd5; len = 5'd2; go = 1'b1;
      tick(); go = 1'b0;
      check("mrst_restart_addr", 32'(mem_addr0), 32'd5);
      tick();
      check("mrst_word0", rd_data, 32'd50);
      tick();
      check("mrst_word1", rd_data, 32'd60);
      tick();
      check("mrst_done", 32'(done), 32'd1);
      tick();

      // go held across done, then go pulsed while busy
      dir = 1'b0; base = 4'd3; len = 5'd1; rd_ready = 1'b1; go = 1'b1;
      tick();
      check("hold_busy", 32'(busy), 32'd1);
      tick();
      check("hold_word", rd_data, 32'd30);
      tick();
      check("hold_done", 32'(done), 32'd1);
      tick();
      check("hold_idle_busy", 32'(busy), 32'd0);
      tick();
      check("hold_restart_busy", 32'(busy), 32'd1);
      check("hold_restart_addr", 32'(mem_addr0), 32'd3);
      go = 1'b0; base = 4'd9;
      tick();
      check("hold_base_ignored", rd_data, 32'd30);
      go = 1'b1;
      tick(); go = 1'b0;
      check("pulse_done", 32'(done), 32'd1);
      tick();
      check("pulse_idle", 32'(busy), 32'd0);
      tick();
      check("pulse_ignored", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
